// File: rtl/fc_argmax_ctrl.sv
// Sequencer for the FC output-stage argmax comparator: fetch scores, clear/run comparator, hand off class.
// Optional watchdog on the comparator run phase is enabled with `define FC_ARGMAX_TIMEOUT_EN.
module fc_argmax_ctrl #(
    parameter int N_CLASSES      = 10,
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 8,
    parameter int BASE_ADDR      = 0,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic                          busy,
    output logic                          mem_rd_en,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic [DATA_W-1:0]             mem_rd_data,
    output logic [N_CLASSES*DATA_W-1:0]   cmp_arr,
    output logic                          cmp_reset,
    output logic                          cmp_enable,
    input  logic                          cmp_done,
    input  logic [3:0]                    cmp_result,
    output logic [3:0]                    class_out,
    output logic                          class_valid,
    input  logic                          class_ready,
    output logic                          timeout_err
);

    localparam int CNT_W = $clog2(N_CLASSES + 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CMP_CLR,
        CMP_RUN,
        HOLD
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [3:0]         class_q, class_d;
    logic [DATA_W-1:0]  bank [N_CLASSES];

`ifdef FC_ARGMAX_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0]   tmr, tmr_d;
    logic               terr_q, terr_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            class_q <= '0;
`ifdef FC_ARGMAX_TIMEOUT_EN
            tmr     <= '0;
            terr_q  <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            class_q <= class_d;
`ifdef FC_ARGMAX_TIMEOUT_EN
            tmr     <= tmr_d;
            terr_q  <= terr_d;
`endif
        end
    end

    // Read k is issued when cnt==k; its data lands when cnt==k+1, so slot k is written then.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < N_CLASSES; k++) bank[k] <= '0;
        end else if (state == FETCH) begin
            for (int unsigned k = 0; k < N_CLASSES; k++) begin
                if (cnt == CNT_W'(k + 1)) bank[k] <= mem_rd_data;
            end
        end
    end

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        class_d    = class_q;
        mem_rd_en  = 1'b0;
        mem_addr   = '0;
        cmp_reset  = 1'b0;
        cmp_enable = 1'b0;
`ifdef FC_ARGMAX_TIMEOUT_EN
        tmr_d      = tmr;
        terr_d     = terr_q;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    cnt_d   = '0;
                end
            end
            FETCH: begin
                if (cnt == CNT_W'(N_CLASSES)) begin
                    state_d = CMP_CLR;
                end else begin
                    mem_rd_en = 1'b1;
                    mem_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(cnt);
                    cnt_d     = cnt + 1'b1;
                end
            end
            CMP_CLR: begin
                cmp_reset = 1'b1;
                state_d   = CMP_RUN;
`ifdef FC_ARGMAX_TIMEOUT_EN
                tmr_d     = '0;
`endif
            end
            CMP_RUN: begin
                cmp_enable = 1'b1;
                if (cmp_done) begin
                    class_d = cmp_result;
                    state_d = HOLD;
                end
`ifdef FC_ARGMAX_TIMEOUT_EN
                else if (tmr == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    class_d = 4'hF;
                    terr_d  = 1'b1;
                    state_d = HOLD;
                end else begin
                    tmr_d = tmr + 1'b1;
                end
`endif
            end
            HOLD: begin
                if (class_ready) begin
`ifdef FC_ARGMAX_TIMEOUT_EN
                    terr_d = 1'b0;
`endif
                    if (start) begin
                        state_d = FETCH;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmp_arr = '0;
        for (int unsigned k = 0; k < N_CLASSES; k++) cmp_arr[k*DATA_W +: DATA_W] = bank[k];
    end

    assign busy        = (state != IDLE);
    assign class_valid = (state == HOLD);
    assign class_out   = class_q;

`ifdef FC_ARGMAX_TIMEOUT_EN
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_fc_argmax_ctrl.sv
// Directed self-checking bench for fc_argmax_ctrl with a score buffer and comparator model.
module tb_fc_argmax_ctrl;

    localparam int N  = 10;
    localparam int DW = 16;
    localparam int AW = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            busy;
    logic            mem_rd_en;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_rd_data = '0;
    logic [N*DW-1:0] cmp_arr;
    logic            cmp_reset;
    logic            cmp_enable;
    logic            cmp_done;
    logic [3:0]      cmp_result = 4'd2;
    logic [3:0]      class_out;
    logic            class_valid;
    logic            class_ready = 1'b0;
    logic            timeout_err;

    logic [DW-1:0]   mem [16];
    logic [3:0]      run_cnt = '0;
    logic            done_en = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    fc_argmax_ctrl #(
        .N_CLASSES(N), .DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(0), .TIMEOUT_CYCLES(32)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .cmp_arr(cmp_arr), .cmp_reset(cmp_reset), .cmp_enable(cmp_enable),
        .cmp_done(cmp_done), .cmp_result(cmp_result),
        .class_out(class_out), .class_valid(class_valid), .class_ready(class_ready),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr[3:0]];

    // Comparator finishes on its 4th enabled cycle after a clear.
    always @(posedge clk) begin
        if (cmp_reset)       run_cnt <= '0;
        else if (cmp_enable) run_cnt <= run_cnt + 1'b1;
    end
    assign cmp_done = done_en && cmp_enable && (run_cnt >= 4'd3);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] slot(input int k);
        return cmp_arr[k*DW +: DW];
    endfunction

    task automatic wait_valid(input int max_cyc);
        int c = 0;
        while (!class_valid && c < max_cyc) begin
            tick();
            c++;
        end
        chk("valid_reached", {31'd0, class_valid}, 32'd1);
    endtask

    initial begin
        int drops;
        int vcnt;
        int ecnt;
        logic [15:0] scores [N];
        scores = '{16'd5, 16'hFFFD, 16'd100, 16'd7, 16'd0, 16'd2, 16'd9, 16'd1, 16'hFFCE, 16'd3};
        for (int i = 0; i < 16; i++) mem[i] = (i < N) ? scores[i] : 16'hDEAD;

        // Reset state
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, class_valid}, 32'd0);
        chk("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("rst_arr", {31'd0, (cmp_arr == '0)}, 32'd1);
        chk("rst_cls", {28'd0, class_out}, 32'd0);
        chk("rst_terr", {31'd0, timeout_err}, 32'd0);
        reset = 1'b0;
        tick();

        // Basic inference
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            chk("fetch_rd_en", {31'd0, mem_rd_en}, 32'd1);
            chk("fetch_addr", {24'd0, mem_addr}, k);
            chk("fetch_noclr", {31'd0, cmp_reset}, 32'd0);
            tick();
        end
        chk("fetch_last_rd_off", {31'd0, mem_rd_en}, 32'd0);
        chk("fetch_last_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("clr_reset", {31'd0, cmp_reset}, 32'd1);
        chk("clr_enable", {31'd0, cmp_enable}, 32'd0);
        tick();
        chk("run_reset", {31'd0, cmp_reset}, 32'd0);
        chk("run_enable", {31'd0, cmp_enable}, 32'd1);
        chk("slot2", {16'd0, slot(2)}, 32'd100);
        chk("slot1", {16'd0, slot(1)}, 32'h0000FFFD);
        chk("slot8", {16'd0, slot(8)}, 32'h0000FFCE);
        chk("slot9", {16'd0, slot(9)}, 32'd3);
        wait_valid(50);
        chk("cls_basic", {28'd0, class_out}, 32'd2);
        chk("hold_enable_off", {31'd0, cmp_enable}, 32'd0);

        // Hold with class_ready low; start pulses ignored
        for (int i = 0; i < 20; i++) begin
            start = (i % 5 == 2);
            tick();
            chk("hold_cls", {28'd0, class_out}, 32'd2);
            chk("hold_valid", {31'd0, class_valid}, 32'd1);
            chk("hold_busy", {31'd0, busy}, 32'd1);
        end
        start = 1'b0;
        chk("hold_no_fetch", {31'd0, mem_rd_en}, 32'd0);

        // Back-to-back: handshake and start in the same cycle
        cmp_result  = 4'd7;
        class_ready = 1'b1;
        start       = 1'b1;
        tick();
        class_ready = 1'b0;
        start       = 1'b0;
        chk("b2b_rd_en", {31'd0, mem_rd_en}, 32'd1);
        chk("b2b_addr", {24'd0, mem_addr}, 32'd0);
        chk("b2b_valid", {31'd0, class_valid}, 32'd0);
        drops = 0;
        for (int c = 0; c < 60 && !class_valid; c++) begin
            if (!busy) drops++;
            tick();
        end
        chk("b2b_busy_drops", drops, 32'd0);
        chk("b2b_valid_reached", {31'd0, class_valid}, 32'd1);
        chk("b2b_cls", {28'd0, class_out}, 32'd7);
        class_ready = 1'b1;
        tick();
        class_ready = 1'b0;
        chk("b2b_idle_busy", {31'd0, busy}, 32'd0);

        // Reset during CMP_RUN (cycle 14 after start)
        cmp_result = 4'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (13) tick();
        chk("abort_pre_enable", {31'd0, cmp_enable}, 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_enable", {31'd0, cmp_enable}, 32'd0);
        chk("abort_valid", {31'd0, class_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_bank_clr", {16'd0, slot(2)}, 32'd0);
        tick();
        reset = 1'b0;
        vcnt = 0;
        for (int c = 0; c < 25; c++) begin
            if (class_valid || busy) vcnt++;
            tick();
        end
        chk("abort_quiet", vcnt, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rerun_addr0", {24'd0, mem_addr}, 32'd0);
        wait_valid(50);
        chk("rerun_cls", {28'd0, class_out}, 32'd4);
        chk("rerun_slot2", {16'd0, slot(2)}, 32'd100);
        class_ready = 1'b1;
        tick();
        class_ready = 1'b0;

        // start pulse during FETCH cycle 3 is ignored
        cmp_result  = 4'd9;
        class_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            chk("ign_addr", {24'd0, mem_addr}, k);
            start = (k == 3);
            tick();
            start = 1'b0;
        end
        vcnt = 0;
        for (int c = 0; c < 60; c++) begin
            if (class_valid) begin
                vcnt++;
                chk("ign_cls", {28'd0, class_out}, 32'd9);
            end
            tick();
        end
        chk("ign_one_valid", vcnt, 32'd1);
        chk("ign_idle", {31'd0, busy}, 32'd0);
        class_ready = 1'b0;
        chk("no_terr", {31'd0, timeout_err}, 32'd0);

`ifdef FC_ARGMAX_TIMEOUT_EN
        // Watchdog: comparator never finishes
        done_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        ecnt = 0;
        for (int c = 0; c < 100 && !class_valid; c++) begin
            if (cmp_enable) ecnt++;
            tick();
        end
        chk("to_valid", {31'd0, class_valid}, 32'd1);
        chk("to_run_cycles", ecnt, 32'd32);
        chk("to_cls", {28'd0, class_out}, 32'hF);
        chk("to_terr", {31'd0, timeout_err}, 32'd1);
        class_ready = 1'b1;
        tick();
        class_ready = 1'b0;
        chk("to_terr_clr", {31'd0, timeout_err}, 32'd0);
        chk("to_valid_clr", {31'd0, class_valid}, 32'd0);
        done_en = 1'b1;
`else
        ecnt = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fc_argmax_ctrl.md
Name: fc_argmax_ctrl

Overview:
Sequencer for the FC output stage's argmax comparator.
- Reads N_CLASSES signed scores from the FC score buffer into a local register bank.
- Drives that bank onto the comparator's array input, then clears and runs the comparator.
- Returns the winning class index to downstream logic over a valid/ready handshake.

Parameters:
N_CLASSES, 10, number of class scores per inference (comparator array depth).
DATA_W, 16, score width in bits (signed two's complement).
ADDR_W, 8, score buffer address width.
BASE_ADDR, 0, buffer address of score 0; score k is at BASE_ADDR+k.
TIMEOUT_CYCLES, 32, watchdog limit for the CMP_RUN state (optional feature only).

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  single-cycle request to classify the current buffer contents.
busy  out  1  high in every state except IDLE.
mem_rd_en  out  1  score buffer read strobe.
mem_addr  out  ADDR_W  score buffer read address.
mem_rd_data  in  DATA_W  read data, valid exactly one cycle after mem_rd_en.
cmp_arr  out  N_CLASSES*DATA_W  flattened bank; slot k occupies bits [k*DATA_W +: DATA_W].
cmp_reset  out  1  synchronous clear pulse to the comparator.
cmp_enable  out  1  comparator run enable.
cmp_done  in  1  comparator completion flag.
cmp_result  in  4  comparator winning index.
class_out  out  4  registered winning class.
class_valid  out  1  class_out valid.
class_ready  in  1  downstream accepts class_out.
timeout_err  out  1  watchdog fired (held 0 when feature is compiled out).

Behaviour:
- Reset (async) drives the FSM to IDLE and clears outputs and state. Cleared: all outputs, the bank, and the counters.
- States:
  - IDLE:
    - On start=1, go to FETCH with read counter=0.
    - Otherwise stay.
  - FETCH:
    - Assert mem_rd_en for N_CLASSES consecutive cycles with mem_addr=BASE_ADDR+k.
    - Capture mem_rd_data into slot k on the cycle after read k.
    - FETCH lasts N_CLASSES+1 cycles; after the final capture, go to CMP_CLR.
  - CMP_CLR:
    - One cycle with cmp_reset=1 and cmp_enable=0.
    - The two strobes are never high together.
    - Next state: CMP_RUN.
  - CMP_RUN:
    - cmp_enable=1 while in this state.
    - On the first cycle cmp_done=1, latch cmp_result into class_out, drop cmp_enable, and go to HOLD.
  - HOLD:
    - class_valid=1; class_out is stable until accepted.
    - Handshake completes when class_valid && class_ready. Then:
      - If start=1 in the same cycle, go directly to FETCH (back-to-back).
      - Otherwise go to IDLE.
- start is ignored in FETCH, CMP_CLR and CMP_RUN; requests are not queued.
- The bank is frozen from CMP_CLR until the next FETCH and is not cleared between inferences.
- cmp_done=1 arriving in CMP_CLR is ignored; only CMP_RUN samples it.
- Reset asserted mid-FETCH or mid-CMP_RUN aborts immediately:
  - no class_valid is produced;
  - cmp_enable drops asynchronously.
- Latency from start to class_valid: N_CLASSES+1 (FETCH) + 1 (CMP_CLR) + comparator run time + 1.
- busy=1 from the cycle after start until the HOLD handshake completes.

Optional Feature:
Macro FC_ARGMAX_TIMEOUT_EN.
- Defined:
  - A counter runs in CMP_RUN.
  - If cmp_done has not been seen after TIMEOUT_CYCLES cycles, the block sets class_out=4'hF and timeout_err=1, and goes to HOLD.
  - timeout_err clears on the HOLD handshake or on reset.
- Undefined:
  - No counter.
  - CMP_RUN waits for cmp_done indefinitely.
  - timeout_err is tied to 0.

Test Plan:
- Buffer holds {5,-3,100,7,0,2,9,1,-50,3}; comparator model returns 2; start pulse.
  - mem_addr steps 0..9 on 10 consecutive cycles.
  - cmp_arr slot 2 = 100.
  - cmp_reset pulses exactly once before cmp_enable rises.
  - class_out=2 and class_valid=1; held until class_ready=1.
- Hold class_ready=0 for 20 cycles with class_valid high.
  - class_out stays constant.
  - start pulses during that hold are ignored.
  - busy stays 1.
- In HOLD, raise class_ready=1 and start=1 in the same cycle.
  - The next cycle is FETCH with mem_rd_en=1 and mem_addr=0.
  - busy never drops.
- Assert reset for 1 cycle while in CMP_RUN (cycle 14 after start).
  - cmp_enable=0, class_valid=0 and busy=0 immediately.
  - A later start runs a full clean sequence.
- Pulse start during FETCH cycle 3.
  - No change to the read sequence.
  - Exactly one class_valid results.
- With FC_ARGMAX_TIMEOUT_EN defined, hold cmp_done=0.
  - After 32 CMP_RUN cycles: class_out=4'hF, timeout_err=1, class_valid=1.
  - The handshake clears timeout_err.
